sev_seg_scan_driver: RTL and testbench
======================================

# sev_seg_scan_driver

Parametrised, time-multiplexed seven-segment display driver for the RAT MCU output path on Basys3. It captures an unsigned binary value on a load strobe and converts it to decimal with a sequential double-dabble engine, or passes it through as hex. It scans any number of common-anode digits, with leading-zero blanking, per-digit decimal points and an overflow indication. It replaces the fixed 4-digit combinational driver; the rest of the design sees only a load/busy interface.

## Interface

- NUM_DIGITS, 4: number of displayed digits, 2..8.
- DATA_W, 16: input value width, 4..32.
- SCAN_DIV, 100_000: CLK cycles per digit slot (1 kHz digit rate at 100 MHz); must be ≥2.
- CLK  in  1  100 MHz system clock; all state on rising edge.
- RST  in  1  reset, synchronous and active-high.
- LOAD  in  1  capture DATA_IN, MODE and BLANK_LZ when BUSY=0; ignored when BUSY=1.
- MODE  in  1  0 = hex, 1 = decimal; sampled with LOAD.
- BLANK_LZ  in  1  1 = suppress leading zeros; sampled with LOAD.
- DATA_IN  in  DATA_W  unsigned value to display.
- DP_IN  in  NUM_DIGITS  decimal point per digit, active-high, live (not latched).
- BUSY  out  1  decimal conversion in progress.
- OVERFLOW  out  1  last loaded value does not fit in NUM_DIGITS digits.
- CATHODES  out  8  {dp,a,b,c,d,e,f,g}, active-low, registered.
- ANODES  out  NUM_DIGITS  digit enables, active-low, one-hot-low, registered. Bit 0 is the least-significant (rightmost) digit.

## Operation

- FSM states: IDLE, CONV.
- IDLE with LOAD=1 and MODE=0: the digit register takes the low 4·NUM_DIGITS bits of DATA_IN next cycle. OVERFLOW is set if any higher bit is nonzero. The state stays IDLE.
- IDLE with LOAD=1 and MODE=1: the value is latched into the shift register, the BCD accumulator is cleared, and the FSM goes to CONV.
- CONV performs one double-dabble step per cycle for DATA_W cycles: add 3 to each BCD nibble ≥5, then shift left one bit. The accumulator holds NUM_DIGITS nibbles plus a sticky carry-out bit.
- On the last step, the digit register and OVERFLOW are written together, and the FSM returns to IDLE. The displayed value never shows a partial conversion.
- Overflow condition (decimal): value > 10^NUM_DIGITS − 1.
- When OVERFLOW=1, every digit shows a dash (segment g only). DP_IN is still honoured.
- Leading-zero blanking (BLANK_LZ=1): each digit above the most significant nonzero digit is blank. Digit 0 is always lit.
- Scan: a prescaler counts 0..SCAN_DIV−1. On wrap, the digit index advances by one and wraps from NUM_DIGITS−1 to 0.
- Output registers are updated every cycle:
  - ANODES = ~(1 << index).
  - CATHODES = {~DP_IN[index], seg(digit[index])}, or 7'b1111111 for the segment bits when the digit is blanked.
- Hex glyphs 0-9 and A, b, C, d, E, F use the package table.

## Timing

- Reset (cycle with RST=1) forces the following values on the next edge:
  - ANODES = all 1s and CATHODES = 8'hFF.
  - BUSY = 0 and OVERFLOW = 0.
  - Digit register = 0, latched BLANK_LZ = 0.
  - Prescaler = 0, index = 0, FSM = IDLE.
- First cycle after reset release: ANODES = ~1 and CATHODES = 8'h81 ("0").
- Reset during CONV aborts the conversion; no partial result is written.
- Hex load: LOAD sampled at edge t → digit register valid after t+1 → visible on the pins at t+2 if that digit is selected.
- Decimal load: LOAD sampled at edge t → BUSY=1 for cycles t+1..t+DATA_W → digit register and OVERFLOW valid and BUSY=0 after edge t+DATA_W+1 → next LOAD accepted in that cycle.
- LOAD while BUSY=1 is dropped with no side effects. Pulses are not queued.
- DP_IN changes reach CATHODES one cycle later.
- Each digit is enabled for exactly SCAN_DIV cycles. A full refresh takes NUM_DIGITS·SCAN_DIV cycles.

## Structure

- Package sev_seg_pkg holds:
  - the 16-entry segment table constant, {a..g} active-low;
  - SEG_BLANK = 7'h7F and SEG_DASH = 7'h7E;
  - an enum for the FSM state and an enum for the display mode.
- Sub-module bin2bcd_seq contains the iterative double-dabble engine (CLK, RST, START, BIN, BUSY, DONE, BCD, OVF), parametrised by DATA_W and NUM_DIGITS.
- The top level holds the load control, digit register, blanking logic and scan counter.

## Test plan

Defaults apply except SCAN_DIV=4.

- Decimal load 16'd1234, BLANK_LZ=0:
  - BUSY is high for exactly 16 cycles.
  - Digits 3..0 show CATHODES 8'hCF ("1"), 8'h92, 8'h86, 8'hCC.
  - OVERFLOW=0.
- Decimal loads 9999 then 10000:
  - 9999 → all "9" (8'h84), OVERFLOW=0.
  - 10000 → all digits 8'hFE, OVERFLOW=1.
- Hex load 16'hBEEF:
  - Result is ready two cycles after LOAD; BUSY is never asserted.
  - Digit 3 = 8'hE0 ("b").
- Decimal 16'd7 with BLANK_LZ=1:
  - Digits 3..1 have CATHODES 8'hFF.
  - Digit 0 = 8'h8F.
  - DP_IN=4'b0001 → digit 0 = 8'h0F.
- Second LOAD (hex 16'h1111) issued mid-conversion:
  - It is ignored; the decimal result stands.
  - RST asserted mid-CONV → display returns to "0000", BUSY=0 next cycle.
- Scan check: ANODES cycles through 1110 → 1101 → 1011 → 0111 → 1110 with each value held 4 cycles, and never has more than one bit low.

Source files
------------

// File: rtl/sev_seg_pkg.sv
// Shared constants and types for the seven-segment scan driver.
// Segment patterns are {a,b,c,d,e,f,g}, active-low.
package sev_seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h7E;

  // Index 15 first: F E d C b A 9 8 7 6 5 4 3 2 1 0
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h38, 7'h30, 7'h42, 7'h31, 7'h60, 7'h08, 7'h04, 7'h00,
    7'h0F, 7'h20, 7'h24, 7'h4C, 7'h06, 7'h12, 7'h4F, 7'h01
  };

  typedef enum logic {ST_IDLE, ST_CONV} state_e;
  typedef enum logic {MODE_HEX = 1'b0, MODE_DEC = 1'b1} mode_e;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    return SEG_TABLE[d];
  endfunction

endpackage

// File: rtl/sev_seg_scan_driver_if.sv
// Load/busy interface between the MCU output path and the display driver.
interface sev_seg_scan_driver_if #(parameter int DATA_W = 16);
  logic              load;
  logic              mode;
  logic              blank_lz;
  logic [DATA_W-1:0] data_in;
  logic              busy;
  logic              overflow;

  modport master (output load, mode, blank_lz, data_in, input busy, overflow);
  modport slave  (input load, mode, blank_lz, data_in, output busy, overflow);
endinterface

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble: one add-3/shift step per cycle for DATA_W cycles.
// done/bcd/ovf are combinational and describe the result of the step taken this cycle.
module bin2bcd_seq #(
  parameter int DATA_W     = 16,
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [DATA_W-1:0]       bin,
  output logic                    busy,
  output logic                    done,
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic                    ovf
);
  localparam int DW = 4*NUM_DIGITS;
  localparam int CW = $clog2(DATA_W+1);

  logic [DATA_W-1:0] sh_q;
  logic [DW-1:0]     acc_q, adj;
  logic              carry_q;
  logic [CW-1:0]     cnt_q;

  always_comb begin
    adj = acc_q;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (acc_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
  end

  // Bit shifted out of the top nibble means the value reached 10^NUM_DIGITS.
  assign bcd  = {adj[DW-2:0], sh_q[DATA_W-1]};
  assign ovf  = carry_q | adj[DW-1];
  assign done = busy && (cnt_q == CW'(DATA_W-1));

  always_ff @(posedge clk) begin
    if (rst) begin
      busy    <= 1'b0;
      cnt_q   <= '0;
      sh_q    <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
    end else if (!busy) begin
      if (start) begin
        busy    <= 1'b1;
        cnt_q   <= '0;
        sh_q    <= bin;
        acc_q   <= '0;
        carry_q <= 1'b0;
      end
    end else begin
      acc_q   <= bcd;
      carry_q <= ovf;
      sh_q    <= sh_q << 1;
      cnt_q   <= cnt_q + 1'b1;
      if (done) busy <= 1'b0;
    end
  end
endmodule

// File: rtl/sev_seg_scan_driver.sv
// Time-multiplexed common-anode display driver: load control, digit register,
// leading-zero blanking, overflow dashes and the digit scan.
module sev_seg_scan_driver
  import sev_seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int DATA_W     = 16,
  parameter int SCAN_DIV   = 100_000
) (
  input  logic                  clk,
  input  logic                  rst,
  sev_seg_scan_driver_if.slave  bus,
  input  logic [NUM_DIGITS-1:0] dp_in,
  output logic [7:0]            cathodes,
  output logic [NUM_DIGITS-1:0] anodes
);
  localparam int DW = 4*NUM_DIGITS;
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = $clog2(NUM_DIGITS);

  state_e                     state;
  logic                       busy_q, ovf_q, blank_q;
  logic [NUM_DIGITS-1:0][3:0] dig_q;
  logic [PW-1:0]              pre;
  logic [IW-1:0]              idx;

  logic                       eng_start, eng_busy, eng_done, eng_ovf;
  logic [DW-1:0]              eng_bcd;
  logic [DATA_W+DW-1:0]       ext;
  logic                       hex_ovf;

  assign ext      = {{DW{1'b0}}, bus.data_in};
  assign hex_ovf  = |ext[DATA_W+DW-1:DW];
  assign eng_start = (state == ST_IDLE) && bus.load && (mode_e'(bus.mode) == MODE_DEC);

  bin2bcd_seq #(.DATA_W(DATA_W), .NUM_DIGITS(NUM_DIGITS)) u_bcd (
    .clk  (clk),
    .rst  (rst),
    .start(eng_start),
    .bin  (bus.data_in),
    .busy (eng_busy),
    .done (eng_done),
    .bcd  (eng_bcd),
    .ovf  (eng_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
      blank_q <= 1'b0;
      dig_q   <= '0;
    end else begin
      case (state)
        ST_IDLE: if (bus.load) begin
          blank_q <= bus.blank_lz;
          if (mode_e'(bus.mode) == MODE_DEC) begin
            state  <= ST_CONV;
            busy_q <= 1'b1;
          end else begin
            dig_q <= ext[DW-1:0];
            ovf_q <= hex_ovf;
          end
        end
        ST_CONV: if (eng_done) begin
          dig_q  <= eng_bcd;
          ovf_q  <= eng_ovf;
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end else if (!eng_busy) begin
          // Engine lost its conversion; recover without touching the display.
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.overflow = ovf_q;

  // zero_above[i]: digits i..NUM_DIGITS-1 are all zero
  logic [NUM_DIGITS-1:0] zero_above;
  logic                  blank;
  logic [6:0]            seg_bits;

  always_comb begin
    zero_above = '0;
    zero_above[NUM_DIGITS-1] = (dig_q[NUM_DIGITS-1] == 4'd0);
    for (int i = NUM_DIGITS-2; i >= 0; i--)
      zero_above[i] = zero_above[i+1] && (dig_q[i] == 4'd0);
    blank    = blank_q && zero_above[idx] && (idx != '0);
    seg_bits = ovf_q ? SEG_DASH : (blank ? SEG_BLANK : seg_of(dig_q[idx]));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre      <= '0;
      idx      <= '0;
      anodes   <= '1;
      cathodes <= 8'hFF;
    end else begin
      if (pre == PW'(SCAN_DIV-1)) begin
        pre <= '0;
        idx <= (idx == IW'(NUM_DIGITS-1)) ? '0 : idx + 1'b1;
      end else begin
        pre <= pre + 1'b1;
      end
      anodes   <= ~(NUM_DIGITS'(1) << idx);
      cathodes <= {~dp_in[idx], seg_bits};
    end
  end
endmodule

// File: tb/tb_sev_seg_scan_driver.sv
// Randomised scoreboard bench for sev_seg_scan_driver (4 digits, 16-bit, SCAN_DIV=4).
module tb_sev_seg_scan_driver;
  localparam int ND = 4;
  localparam int DW = 16;
  localparam int SD = 4;

  typedef struct packed {
    logic [ND-1:0][7:0] cat;
    logic               ovf;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [ND-1:0] dp_in = '0;
  logic [7:0]    cathodes;
  logic [ND-1:0] anodes;

  int checks = 0;
  int failures = 0;

  exp_t sb_q[$];
  logic [ND-1:0][7:0] shown;
  event settle_ev;

  sev_seg_scan_driver_if #(.DATA_W(DW)) bif ();

  sev_seg_scan_driver #(.NUM_DIGITS(ND), .DATA_W(DW), .SCAN_DIV(SD)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bif),
    .dp_in   (dp_in),
    .cathodes(cathodes),
    .anodes  (anodes)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] glyph(input int d);
    case (d)
      0: return 8'h81;  1: return 8'hCF;  2: return 8'h92;  3: return 8'h86;
      4: return 8'hCC;  5: return 8'hA4;  6: return 8'hA0;  7: return 8'h8F;
      8: return 8'h80;  9: return 8'h84; 10: return 8'h88; 11: return 8'hE0;
     12: return 8'hB1; 13: return 8'hC2; 14: return 8'hB0; 15: return 8'hB8;
      default: return 8'hFF;
    endcase
  endfunction

  // Expected display from plain arithmetic on the loaded value.
  function automatic exp_t model(input int v, input bit dec, input bit blz, input logic [ND-1:0] dp);
    exp_t e;
    int base = dec ? 10 : 16;
    int lim = base * base * base * base;
    int val = v % lim;
    int pw = 1;
    logic [7:0] s;
    e.ovf = (v >= lim);
    for (int i = 0; i < ND; i++) begin
      if (e.ovf) s = 8'hFE;
      else if (blz && i > 0 && (val / pw) == 0) s = 8'hFF;
      else s = glyph((val / pw) % base);
      if (dp[i]) s[7] = 1'b0;
      e.cat[i] = s;
      pw = pw * base;
    end
    return e;
  endfunction

  task automatic settle();
    repeat (ND*SD + 3) @(negedge clk);
    -> settle_ev;
    @(negedge clk);
  endtask

  // inject > 0: pulse a hex LOAD of 16'h1111 on that busy cycle; it must be dropped.
  task automatic do_load(input int v, input bit dec, input bit blz, input logic [ND-1:0] dp, input int inject);
    int n;
    exp_t e;
    e = model(v, dec, blz, dp);
    sb_q.push_back(e);
    @(negedge clk);
    bif.data_in = 16'(v); bif.mode = dec; bif.blank_lz = blz; dp_in = dp; bif.load = 1'b1;
    @(negedge clk);
    bif.load = 1'b0;
    n = 0;
    if (dec) begin
      while (bif.busy === 1'b1 && n < 100) begin
        n++;
        @(negedge clk);
        if (n == inject) begin
          bif.load = 1'b1; bif.mode = 1'b0; bif.blank_lz = ~blz; bif.data_in = 16'h1111;
        end else bif.load = 1'b0;
      end
      bif.load = 1'b0;
      chk("busy_len", 64'(n), 64'(DW));
      chk("ovf_at_done", 64'(bif.overflow), 64'(e.ovf));
    end else begin
      repeat (3) begin
        if (bif.busy !== 1'b0) n++;
        @(negedge clk);
      end
      chk("hex_no_busy", 64'(n), 64'd0);
    end
    settle();
  endtask

  // Display snapshot and scan-order monitor
  logic [ND-1:0] prev_an = '1;
  int run_len = 0;
  bit run_valid = 0;
  always @(negedge clk) begin
    for (int i = 0; i < ND; i++)
      if (anodes == ~(4'b0001 << i)) shown[i] = cathodes;
    if (rst) begin
      prev_an = '1; run_len = 0; run_valid = 0;
    end else if (anodes !== prev_an) begin
      chk("anode_onehot", 64'($countones(~anodes)), 64'd1);
      if (prev_an != '1) begin
        chk("anode_order", 64'(anodes), 64'({prev_an[ND-2:0], prev_an[ND-1]}));
        if (run_valid) chk("anode_hold", 64'(run_len), 64'(SD));
        run_valid = 1;
      end
      prev_an = anodes;
      run_len = 1;
    end else begin
      run_len++;
    end
  end

  always @(settle_ev) begin
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++; failures++;
      $display("FAIL sb_pop actual=empty required=entry");
    end else begin
      e = sb_q.pop_front();
      for (int i = 0; i < ND; i++) chk($sformatf("digit%0d", i), 64'(shown[i]), 64'(e.cat[i]));
      chk("overflow", 64'(bif.overflow), 64'(e.ovf));
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int v;
    bit dec, blz;
    logic [ND-1:0] dp;
    bif.load = 0; bif.mode = 0; bif.blank_lz = 0; bif.data_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_anodes", 64'(anodes), 64'hF);
    chk("rst_cathodes", 64'(cathodes), 64'hFF);
    chk("rst_busy", 64'(bif.busy), 64'd0);
    chk("rst_overflow", 64'(bif.overflow), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("first_anodes", 64'(anodes), 64'hE);
    chk("first_cathodes", 64'(cathodes), 64'h81);

    do_load(1234, 1, 0, 4'b0000, 0);
    do_load(9999, 1, 0, 4'b0000, 0);
    do_load(10000, 1, 0, 4'b0000, 0);
    do_load(16'hBEEF, 0, 0, 4'b0000, 0);
    do_load(7, 1, 1, 4'b0000, 0);
    dp_in = 4'b0001;
    sb_q.push_back(model(7, 1, 1, 4'b0001));
    settle();
    do_load(42, 1, 0, 4'b0000, 5);

    // Reset in the middle of a conversion
    @(negedge clk);
    bif.data_in = 16'd5678; bif.mode = 1; bif.blank_lz = 1; bif.load = 1;
    @(negedge clk);
    bif.load = 0;
    repeat (5) @(negedge clk);
    chk("busy_mid", 64'(bif.busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("busy_after_rst", 64'(bif.busy), 64'd0);
    rst = 1'b0;
    sb_q.push_back(model(0, 0, 0, dp_in));
    settle();

    for (int k = 0; k < 14; k++) begin
      case ($urandom_range(0, 3))
        0: v = 9990 + $urandom_range(0, 20);
        1: v = $urandom_range(0, 300);
        default: v = $urandom_range(0, 65535);
      endcase
      dec = 1'($urandom_range(0, 1));
      blz = 1'($urandom_range(0, 1));
      dp  = 4'($urandom_range(0, 15));
      do_load(v, dec, blz, dp, 0);
    end

    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
